uart_rx_8n1: RTL and testbench
==============================

// Module: uart_rx_8n1
// PURPOSE
//   Serial receiver for the board UART_RXD pin: 8 data bits, no parity, 1 stop bit, LSB first.
//   Receiving end of the link driven out on UART_TXD: lets a host send bytes into the design
//   (CPU operand input, instruction-memory loader). Single clock domain (CLOCK_50).
//   Received byte is held in a register until the consumer acknowledges it.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200 baud); must be >= 8
//   HALF_BIT      CLKS_PER_BIT/2  cycles from start-edge detection to mid-start sample
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  reset: synchronous, active-high
//   rxd        in   1  asynchronous serial line, idles high
//   rx_ack     in   1  consumer has taken rx_data; clears rx_valid and overrun
//   rx_data    out  8  last good byte received
//   rx_valid   out  1  level: rx_data holds an unacknowledged byte
//   overrun    out  1  sticky: a byte completed while rx_valid was still 1
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   busy       out  1  FSM is not in IDLE
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//   - FSM -> IDLE; counters 0; rx_data=8'h00; rx_valid, overrun, frame_err, busy = 0
//   - both synchronizer flops = 1. Applies mid-frame: partial byte discarded.
//   Sync: rxd passes two flops (rxd_s); all decisions use rxd_s only, giving 2 cycles of latency.
//   Bit counter: 3 bits, LSB first. Shift register: 8 bits, shifted right with rxd_s into bit 7.
//   Cycle counter: counts 0..CLKS_PER_BIT-1.
//   FSM:
//   - IDLE: rxd_s==0 -> START, cnt=0.
//   - START: at cnt==HALF_BIT-1, sample rxd_s:
//       0 -> DATA, cnt=0, bit=0;
//       1 -> IDLE (glitch rejected, no output change).
//   - DATA: at cnt==CLKS_PER_BIT-1, shift in rxd_s and cnt=0;
//       after bit 7 -> STOP; otherwise bit+1.
//   - STOP: at cnt==CLKS_PER_BIT-1, sample rxd_s:
//       1 -> load rx_data from shift reg, rx_valid=1 next cycle, -> IDLE;
//       0 -> frame_err=1 for one cycle, rx_data/rx_valid unchanged, -> WAIT_IDLE.
//   - WAIT_IDLE: stay until rxd_s==1, then -> IDLE (a break condition produces a single frame_err).
//   Sampling point: mid-bit for every bit.
//   Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT (+/-1) cycles after the rxd falling edge.
//   IDLE is re-entered right after the stop sample, so back-to-back frames need no extra idle time.
//   Output rules, applied at each byte load:
//   - rx_ack with rx_valid=0: ignored.
//   - rx_valid=1, rx_ack=0: new byte overwrites rx_data, rx_valid stays 1, overrun=1.
//   - rx_ack=1 in the same cycle as a byte load: new byte loaded, rx_valid stays 1, overrun=0.
//   - rx_ack alone: rx_valid=0, overrun=0 on the next edge. rx_data keeps its value.
//   - rxd changes during DATA/STOP away from the sample points have no effect.
// TESTING (bench uses CLKS_PER_BIT=16, HALF_BIT=8)
//   1. rst=1 for 2 cycles, rxd=1 -> all outputs 0 and busy=0. Send 8'hA5 -> rx_data=A5, rx_valid=1
//      at 2+8+144 (+/-1) cycles after the falling edge; frame_err never asserted.
//   2. Frames 8'h00 then 8'hFF back-to-back; rx_ack pulsed after each -> both bytes received in
//      order, overrun=0, rx_valid=0 after each ack.
//   3. Send 8'h3C and 8'hC3 with no ack -> rx_data=C3, rx_valid=1, overrun=1.
//      Then rx_ack=1 -> rx_valid=0, overrun=0.
//   4. Send 8'h55 with stop bit held 0 for 3 bit times -> one frame_err pulse, rx_valid unchanged.
//      Busy stays 1 until rxd returns high. A following 8'h81 is received correctly.
//   5. rxd low pulse of 4 cycles -> FSM back to IDLE, no output change. Separately, assert rst
//      during data bit 4 of 8'h7E -> all outputs 0, then a fresh 8'h12 is received correctly.
//   6. rx_ack held 1 during the cycle 8'h9A loads while rx_valid=1 -> rx_data=9A, rx_valid=1, overrun=0.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// uart_rx_8n1
//   Serial receiver for the board UART_RXD pin. The frame format is 8 data bits,
//   no parity and 1 stop bit, sent LSB first. The design runs in one clock domain.
//   Each received byte is held in rx_data until the consumer acknowledges it.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (must be >= 8)
//   HALF_BIT      cycles from start-edge detection to the mid-start sample
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   rxd        in   1  asynchronous serial line, idles high
//   rx_ack     in   1  consumer has taken rx_data; clears rx_valid and overrun
//   rx_data    out  8  last good byte received
//   rx_valid   out  1  level: rx_data holds an unacknowledged byte
//   overrun    out  1  sticky: a byte completed while rx_valid was still 1
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   busy       out  1  receiver FSM is not in IDLE
//
// Handshake: rx_valid is a level that rises when a byte is loaded. rx_valid stays
// high until rx_ack is seen at a clock edge. An rx_ack seen while rx_valid=0 has no
// effect. An rx_ack in the same cycle as a byte load is treated as consuming the
// old byte, so the new byte is left valid and overrun is not flagged.
// ---------------------------------------------------------------------------
module uart_rx_8n1 #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             byte_done;
   logic             stop_bad;
   logic             rxd_m, rxd_s;

   // Two-flop synchronizer. It resets to the idle line level, so a reset can
   // never be seen as a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
      end
   end

   // Next-state logic. Each sample point is the last count of the current
   // interval. Half an interval lands the start sample mid-bit, and later
   // samples are whole bit periods apart, so every sample stays mid-bit.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      byte_done   = 1'b0;
      stop_bad    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!rxd_s) begin
               state_nxt = ST_START;
               cnt_nxt   = '0;
            end
         end

         ST_START: begin
            if (cnt == CNT_HALF) begin
               cnt_nxt = '0;
               if (!rxd_s) begin
                  state_nxt   = ST_DATA;
                  bit_idx_nxt = '0;
               end else begin
                  // The line was low too briefly to be a start bit.
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         ST_DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               shift_nxt = {rxd_s, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_nxt = ST_STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         ST_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (rxd_s) begin
                  byte_done = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = ST_WAIT_IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         ST_WAIT_IDLE: begin
            // A held-low line (break) produces only one frame_err. The FSM
            // waits here until the line returns high.
            if (rxd_s) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Output register and consumer handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         if (byte_done) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            overrun  <= rx_valid & ~rx_ack;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_8n1
//   Testbench for uart_rx_8n1 using CLKS_PER_BIT=16 and HALF_BIT=8.
//   Each frame the driver sends produces one expected event: a byte load or a
//   frame error. The event is scheduled at the cycle given by the receiver's
//   nominal latency. A reference model applies these events and the consumer's
//   rx_ack to the expected outputs. A compare loop checks every cycle.
//   Hand-computed literal checks after each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_uart_rx_8n1;

   localparam int BIT  = 16;
   localparam int HALF = 8;
   localparam int SYNC = 2;
   // The sending edge is cycle n0. The DUT sees the falling edge at n0+1.
   // The byte lands SYNC + HALF + 9*BIT cycles later.
   localparam int LOAD_OFS = 1 + SYNC + HALF + 9 * BIT;

   // Clock / reset
   logic clk;
   logic rst;
   logic rxd;
   logic rx_ack;
   logic [7:0] rx_data;
   logic rx_valid;
   logic overrun;
   logic frame_err;
   logic busy;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   uart_rx_8n1 #(.CLKS_PER_BIT(BIT), .HALF_BIT(HALF)) dut (
      .clk      (clk),
      .rst      (rst),
      .rxd      (rxd),
      .rx_ack   (rx_ack),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .overrun  (overrun),
      .frame_err(frame_err),
      .busy     (busy)
   );

   // Scoreboard state
   // Each exp_q entry is {cycle[31:0], is_load, data[7:0]}.
   logic [40:0] exp_q[$];
   int          cyc       = 0;
   int          n_checks  = 0;
   int          n_fail    = 0;
   int          ferr_cnt  = 0;
   int          rise_cyc  = -1;
   int          last_start = 0;
   bit          chk_en    = 1'b0;
   logic [7:0]  m_data    = 8'h00;
   logic        m_valid   = 1'b0;
   logic        m_overrun = 1'b0;
   logic        m_ferr    = 1'b0;

   // Reference model: advances one cycle per clock edge.
   always @(posedge clk) begin
      logic [40:0] e;
      logic        fire_load;
      logic        fire_ferr;
      logic [7:0]  fire_data;
      cyc = cyc + 1;
      fire_load = 1'b0;
      fire_ferr = 1'b0;
      fire_data = 8'h00;
      if (exp_q.size() > 0) begin
         e = exp_q[0];
         if (int'(e[40:9]) == cyc) begin
            void'(exp_q.pop_front());
            fire_load = e[8];
            fire_ferr = ~e[8];
            fire_data = e[7:0];
         end
      end
      if (rst) begin
         exp_q.delete();
         m_data    = 8'h00;
         m_valid   = 1'b0;
         m_overrun = 1'b0;
         m_ferr    = 1'b0;
      end else begin
         m_ferr = fire_ferr;
         if (fire_load) begin
            // The old byte is lost unless it is acknowledged in this cycle.
            m_overrun = m_valid && !rx_ack;
            m_data    = fire_data;
            m_valid   = 1'b1;
         end else if (rx_ack) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
         end
      end
   end

   // Per-cycle compare, sampled away from the active edge
   initial begin
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            n_checks++;
            if (rx_data !== m_data || rx_valid !== m_valid ||
                overrun !== m_overrun || frame_err !== m_ferr) begin
               n_fail++;
               if (n_fail <= 20)
                  $display("FAIL cycle_check cyc=%0d got data=%h valid=%b ovr=%b ferr=%b, expected data=%h valid=%b ovr=%b ferr=%b",
                           cyc, rx_data, rx_valid, overrun, frame_err,
                           m_data, m_valid, m_overrun, m_ferr);
            end
            if (frame_err === 1'b1) ferr_cnt++;
            if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
         end
         prev_valid = rx_valid;
      end
   end

   // Driver tasks
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      idle(1);
      rx_ack = 1'b0;
   endtask

   // Sends one frame with the stop level held for stop_bits bit periods.
   // If ack_c >= 0, rx_ack is raised during frame cycle ack_c.
   // The line is left at the stop level when the task returns.
   task automatic send_frame(input logic [7:0] d, input int stop_bits,
                             input logic stop_val, input int ack_c);
      int n0;
      int b;
      n0 = cyc;
      last_start = n0;
      exp_q.push_back({32'(n0 + LOAD_OFS), stop_val, d});
      for (int c = 0; c < BIT * (9 + stop_bits); c++) begin
         b = c / BIT;
         if (b == 0)      rxd = 1'b0;
         else if (b <= 8) rxd = d[b-1];
         else             rxd = stop_val;
         rx_ack = (c == ack_c);
         @(posedge clk);
         #1;
      end
      rx_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rxd = 1'b1;
      rx_ack = 1'b0;
      idle(2);
      rst = 1'b0;
   endtask

   // Stimulus
   initial begin
      logic [7:0] d;
      int         mode;
      int         lat;
      rst = 1'b1;
      rxd = 1'b1;
      rx_ack = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      chk_en = 1'b1;

      // 1: reset state, then A5 with latency measurement
      check("reset_data", rx_data, 8'h00);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      send_frame(8'hA5, 1, 1'b1, -1);
      check("a5_data", rx_data, 8'hA5);
      check("a5_valid", rx_valid, 1'b1);
      lat = rise_cyc - (last_start + 1);
      check("a5_latency_in_window", (lat >= 153 && lat <= 155), 1'b1);
      check("a5_no_frame_err", ferr_cnt, 0);
      idle(3);

      // 2: 00 and FF back-to-back, each acknowledged
      pulse_ack();
      check("ack_a5_valid", rx_valid, 1'b0);
      check("ack_a5_data_kept", rx_data, 8'hA5);
      send_frame(8'h00, 1, 1'b1, -1);
      check("b2b_00_data", rx_data, 8'h00);
      check("b2b_00_valid", rx_valid, 1'b1);
      send_frame(8'hFF, 1, 1'b1, 8);
      check("b2b_ff_data", rx_data, 8'hFF);
      check("b2b_ff_overrun", overrun, 1'b0);
      pulse_ack();
      check("b2b_ff_valid_after_ack", rx_valid, 1'b0);
      idle(4);

      // 3: overrun
      send_frame(8'h3C, 1, 1'b1, -1);
      send_frame(8'hC3, 1, 1'b1, -1);
      check("ovr_data", rx_data, 8'hC3);
      check("ovr_valid", rx_valid, 1'b1);
      check("ovr_flag", overrun, 1'b1);
      pulse_ack();
      check("ovr_ack_valid", rx_valid, 1'b0);
      check("ovr_ack_flag", overrun, 1'b0);
      idle(4);

      // 4: stop bit held low for 3 bit times (break)
      send_frame(8'h55, 3, 1'b0, -1);
      check("break_one_frame_err", ferr_cnt, 1);
      check("break_valid_unchanged", rx_valid, 1'b0);
      check("break_busy_held", busy, 1'b1);
      rxd = 1'b1;
      idle(4);
      check("break_busy_released", busy, 1'b0);
      send_frame(8'h81, 1, 1'b1, -1);
      check("after_break_data", rx_data, 8'h81);
      check("after_break_valid", rx_valid, 1'b1);
      idle(4);

      // 5a: 4-cycle glitch is rejected
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      check("glitch_busy_during", busy, 1'b1);
      idle(20);
      check("glitch_busy_after", busy, 1'b0);
      check("glitch_data_unchanged", rx_data, 8'h81);

      // 5b: reset in the middle of data bit 4 of 7E
      d = 8'h7E;
      for (int c = 0; c < 5 * BIT + HALF; c++) begin
         rxd = (c < BIT) ? 1'b0 : d[c / BIT - 1];
         idle(1);
      end
      check("midframe_busy", busy, 1'b1);
      do_reset();
      check("midrst_data", rx_data, 8'h00);
      check("midrst_valid", rx_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      idle(5);
      send_frame(8'h12, 1, 1'b1, -1);
      check("fresh_12_data", rx_data, 8'h12);
      check("fresh_12_valid", rx_valid, 1'b1);
      idle(3);

      // 6: ack coincides with the 9A load while 12 is still valid
      send_frame(8'h9A, 1, 1'b1, LOAD_OFS - 1);
      check("ackload_data", rx_data, 8'h9A);
      check("ackload_valid", rx_valid, 1'b1);
      check("ackload_overrun", overrun, 1'b0);
      pulse_ack();

      // Random frames, acknowledge timing and idle gaps
      for (int i = 0; i < 14; i++) begin
         d = 8'($urandom_range(0, 255));
         mode = $urandom_range(0, 3);
         case (mode)
            0: send_frame(d, 1, 1'b1, -1);
            1: send_frame(d, 1, 1'b1, LOAD_OFS - 1);
            2: send_frame(d, 1, 1'b1, $urandom_range(0, 10 * BIT - 1));
            default: begin
               send_frame(d, 1, 1'b1, -1);
               pulse_ack();
            end
         endcase
         check("rand_data", rx_data, d);
         idle($urandom_range(0, 10));
      end
      idle(5);
      check("no_pending_events", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Overall time bound
   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
